seg_pattern_decoder: RTL and testbench

- Receive side of the seven-segment display interface. Samples a 7-bit segment bus driven by another board or a display driver, debounces it, and decodes the glyph back to a 4-bit hex value.
- Each newly stable glyph is presented once on a valid/ready output.
- Unrecognised patterns are flagged. Blank patterns are ignored.
- Feeds the lab's score/keypad logic, which consumes nibbles instead of raw segments.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_glyph_lookup.sv | 24 ++
 rtl/seg_pattern_decoder.sv | 138 +++++++++++++
 tb/tb_seg_pattern_decoder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment receive path.
//   seg_t       : 7-bit active-low segment pattern, bit0=a .. bit6=g
//   SEG_BLANK   : all segments off
//   GLYPH_TABLE : index = hex value, entry = active-low pattern for that digit
//   state_t     : decoder FSM states
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Packed so that GLYPH_TABLE[i] is the pattern for hex digit i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_PRESENT,
    ST_WAIT_CHANGE
  } state_t;

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational segment-pattern to hex-digit lookup.
//   pattern : active-low segment pattern
//   legal   : pattern is one of the 16 hex glyphs
//   nibble  : decoded value (0 when not legal)
module seg_glyph_lookup
  import seg_pkg::*;
(
  input  seg_t       pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Seven-segment receive decoder: synchronises and debounces a raw segment
// bus, decodes each newly stable glyph to a hex nibble and presents it once
// on a valid/ready output. Illegal patterns raise err_pulse; a legal glyph
// qualifying while the previous nibble is still unaccepted raises
// overrun_pulse and is dropped.
// Optional feature macro: SEG_ERRCNT_EN adds err_count (saturating 8-bit).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   seg_in[6:0]       : raw active-low segment bus (asynchronous)
//   out_ready         : consumer accepts nibble
//   out_valid         : nibble available
//   out_nibble[3:0]   : decoded hex value
//   err_pulse         : one-cycle illegal-pattern flag
//   err_pattern[6:0]  : last illegal pattern
//   overrun_pulse     : one-cycle dropped-glyph flag
//   err_count[7:0]    : (SEG_ERRCNT_EN only) error + overrun count
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       err_pulse,
  output logic [6:0] err_pattern,
  output logic       overrun_pulse
`ifdef SEG_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  seg_t       sync1_q, sync2_q, prev_q, last_q;
  logic [7:0] cnt_q;
  state_t     state_q;
  logic       same, qualify, clear_cnt;
  logic       glyph_legal;
  logic [3:0] glyph_nibble;

  assign same = (sync2_q == prev_q);
  // Qualify on the edge where the count steps up to STABLE_CYCLES, so the
  // FSM reacts in the same cycle the counter saturates.
  assign qualify = same && (cnt_q == STABLE_MAX - 8'd1);
  // Leaving WAIT_CHANGE restarts debouncing even if the counter is saturated
  // (covers a glyph that qualified during the handshake cycle).
  assign clear_cnt = (state_q == ST_WAIT_CHANGE) && (sync2_q != last_q);

  seg_glyph_lookup u_lookup (
    .pattern (sync2_q),
    .legal   (glyph_legal),
    .nibble  (glyph_nibble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SEG_BLANK;
      sync2_q <= SEG_BLANK;
      prev_q  <= SEG_BLANK;
      cnt_q   <= '0;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clear_cnt || !same)
        cnt_q <= '0;
      else if (cnt_q < STABLE_MAX)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SETTLE;
      last_q        <= SEG_BLANK;
      out_valid     <= 1'b0;
      out_nibble    <= '0;
      err_pulse     <= 1'b0;
      err_pattern   <= SEG_BLANK;
      overrun_pulse <= 1'b0;
    end else begin
      err_pulse     <= 1'b0;
      overrun_pulse <= 1'b0;
      case (state_q)
        ST_SETTLE: begin
          if (qualify) begin
            state_q <= ST_WAIT_CHANGE;
            if (sync2_q != last_q) begin
              last_q <= sync2_q;
              if (glyph_legal) begin
                out_valid  <= 1'b1;
                out_nibble <= glyph_nibble;
                state_q    <= ST_PRESENT;
              end else if (sync2_q != SEG_BLANK) begin
                err_pulse   <= 1'b1;
                err_pattern <= sync2_q;
              end
            end
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= ST_WAIT_CHANGE;
          end else if (qualify && (sync2_q != last_q)) begin
            last_q <= sync2_q;
            if (glyph_legal) begin
              overrun_pulse <= 1'b1;
            end else if (sync2_q != SEG_BLANK) begin
              err_pulse   <= 1'b1;
              err_pattern <= sync2_q;
            end
          end
        end
        ST_WAIT_CHANGE: begin
          if (sync2_q != last_q)
            state_q <= ST_SETTLE;
        end
        default: state_q <= ST_SETTLE;
      endcase
    end
  end

`ifdef SEG_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if ((err_pulse || overrun_pulse) && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Self-checking bench for seg_pattern_decoder (STABLE_CYCLES = 4).
// Directed steps from the test plan followed by a randomized phase; every
// cycle is also compared against a behavioural model that keeps the full
// history of sampled bus values and counts trailing identical samples.
module tb_seg_pattern_decoder;

  localparam int STABLE = 4;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam int MODE_SETTLE = 0;
  localparam int MODE_SHOW   = 1;
  localparam int MODE_HOLD   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_nibble;
  logic       err_pulse;
  logic [6:0] err_pattern;
  logic       overrun_pulse;
`ifdef SEG_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [6:0] hist[$];
  int         n_edge;
  int         floor_e;
  int         mode;
  logic [6:0] m_last;
  logic       m_valid;
  logic [3:0] m_nib;
  logic       m_err;
  logic [6:0] m_errpat;
  logic       m_ovr;
  int         m_errcnt;

  seg_pattern_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_nibble    (out_nibble),
    .err_pulse     (err_pulse),
    .err_pattern   (err_pattern),
    .overrun_pulse (overrun_pulse)
`ifdef SEG_ERRCNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int glyph_of(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (p == GLYPHS[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    // sampled values seen at edges 0..2 are the reset fill of the pipeline
    repeat (3) hist.push_back(BLANK);
    n_edge   = 0;
    floor_e  = 0;
    mode     = MODE_SETTLE;
    m_last   = BLANK;
    m_valid  = 1'b0;
    m_nib    = '0;
    m_err    = 1'b0;
    m_errpat = BLANK;
    m_ovr    = 1'b0;
    m_errcnt = 0;
  endtask

  // One clock edge of the reference: hist[m] is the value the decoder judges
  // at edge m (bus value captured two edges earlier).
  task automatic model_edge(input logic [6:0] seg, input logic rdy);
    int run;
    int m;
    int g;
    logic [6:0] s;
    logic q;
    if ((m_err || m_ovr) && m_errcnt != 255) m_errcnt++;
    m_err = 1'b0;
    m_ovr = 1'b0;
    n_edge++;
    hist.push_back(seg);
    s = hist[n_edge];
    run = 0;
    m = n_edge;
    while (m > floor_e && hist[m] == hist[m-1] && run <= STABLE) begin
      run++;
      m--;
    end
    q = (run == STABLE);
    g = glyph_of(s);
    if (mode == MODE_HOLD) begin
      if (s != m_last) begin
        mode    = MODE_SETTLE;
        floor_e = n_edge;
      end
    end else if (mode == MODE_SHOW && rdy) begin
      m_valid = 1'b0;
      mode    = MODE_HOLD;
    end else if (q) begin
      if (mode == MODE_SETTLE) mode = MODE_HOLD;
      if (s != m_last) begin
        m_last = s;
        if (g < 0 && s != BLANK) begin
          m_err    = 1'b1;
          m_errpat = s;
        end else if (g >= 0 && mode == MODE_SHOW) begin
          m_ovr = 1'b1;
        end else if (g >= 0) begin
          m_valid = 1'b1;
          m_nib   = g[3:0];
          mode    = MODE_SHOW;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("valid", {7'b0, out_valid}, {7'b0, m_valid});
    chk("nibble", {4'b0, out_nibble}, {4'b0, m_nib});
    chk("err_pulse", {7'b0, err_pulse}, {7'b0, m_err});
    chk("err_pattern", {1'b0, err_pattern}, {1'b0, m_errpat});
    chk("overrun", {7'b0, overrun_pulse}, {7'b0, m_ovr});
`ifdef SEG_ERRCNT_EN
    chk("err_count", err_count, 8'(m_errcnt));
`endif
  endtask

  task automatic step(input logic [6:0] seg, input logic rdy);
    seg_in    = seg;
    out_ready = rdy;
    @(posedge clk);
    model_edge(seg, rdy);
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    int ovr_cnt;
    logic [6:0] pat;
    logic [6:0] prev_pat;
    int hold;

    rst_n     = 1'b0;
    seg_in    = BLANK;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_nibble", {4'b0, out_nibble}, 8'h00);
    chk("rst_err_pulse", {7'b0, err_pulse}, 8'h00);
    chk("rst_err_pattern", {1'b0, err_pattern}, 8'h7F);
    chk("rst_overrun", {7'b0, overrun_pulse}, 8'h00);
    rst_n = 1'b1;

    // glyph 2, ready high: valid after the 7th edge (k+6 with k = 1), one cycle
    for (int i = 1; i <= 8; i++) begin
      step(7'h24, 1'b1);
      chk("t1_valid", {7'b0, out_valid}, (i == 7) ? 8'h01 : 8'h00);
      if (i == 7) chk("t1_nibble", {4'b0, out_nibble}, 8'h02);
    end

    // glyph 5, consumer stalls 10 cycles
    for (int i = 1; i <= 7; i++) step(7'h12, 1'b0);
    chk("t2_valid_on", {7'b0, out_valid}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      step(7'h12, 1'b0);
      chk("t2_valid_hold", {7'b0, out_valid}, 8'h01);
      chk("t2_nibble_hold", {4'b0, out_nibble}, 8'h05);
    end
    step(7'h12, 1'b1);
    chk("t2_valid_clear", {7'b0, out_valid}, 8'h00);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(7'h12, 1'b1);
      if (out_valid) cnt++;
    end
    chk("t2_no_reemit", 8'(cnt), 8'h00);

    // bouncing between 1 and 3, then settling on 3
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(((i / 2) % 2 == 0) ? 7'h79 : 7'h30, 1'b1);
      if (out_valid) cnt++;
    end
    chk("t3_bounce_quiet", 8'(cnt), 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'h30, 1'b1);
      if (out_valid) begin
        cnt++;
        chk("t3_nibble", {4'b0, out_nibble}, 8'h03);
      end
    end
    chk("t3_one_emit", 8'(cnt), 8'h01);

    // illegal pattern
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'h55, 1'b1);
      if (err_pulse) cnt++;
      chk("t4_no_valid", {7'b0, out_valid}, 8'h00);
    end
    chk("t4_err_once", 8'(cnt), 8'h01);
    chk("t4_err_pattern", {1'b0, err_pattern}, 8'h55);
`ifdef SEG_ERRCNT_EN
    chk("t4_err_count", err_count, 8'h01);
`endif

    // overrun: 8 unaccepted, then 9 qualifies and is dropped
    for (int i = 0; i < 8; i++) step(7'h00, 1'b0);
    chk("t5_valid8", {7'b0, out_valid}, 8'h01);
    ovr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(7'h18, 1'b0);
      if (overrun_pulse) ovr_cnt++;
      chk("t5_nibble_kept", {4'b0, out_nibble}, 8'h08);
    end
    chk("t5_overrun_once", 8'(ovr_cnt), 8'h01);
    step(7'h18, 1'b1);
    chk("t5_valid_clear", {7'b0, out_valid}, 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(7'h18, 1'b1);
      if (out_valid) cnt++;
    end
    chk("t5_no_nine", 8'(cnt), 8'h00);

    // reset while a nibble is pending
    for (int i = 0; i < 7; i++) step(7'h24, 1'b0);
    chk("t6_pending", {7'b0, out_valid}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", {7'b0, out_valid}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(7'h24, 1'b0);
      chk("t6_reemit", {7'b0, out_valid}, (i >= 7) ? 8'h01 : 8'h00);
    end
    chk("t6_nibble", {4'b0, out_nibble}, 8'h02);
    step(7'h24, 1'b1);

    // randomized traffic
    prev_pat = 7'h24;
    for (int seg_i = 0; seg_i < 300; seg_i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pat = GLYPHS[$urandom_range(0, 15)];
        6, 7:             pat = BLANK;
        8:                pat = 7'($urandom_range(0, 127));
        default:          pat = prev_pat;
      endcase
      hold = $urandom_range(1, 10);
      for (int h = 0; h < hold; h++)
        step(pat, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      prev_pat = pat;
    end
    for (int i = 0; i < 12; i++) step(prev_pat, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
